// File: rtl/dragon_head_ctrl.sv
// dragon_head_ctrl: chases the target one tile per movement period and
// turns heal/hit events into one-cycle grow/shrink pulses for the body.
module dragon_head_ctrl #(
  parameter int         MOVE_PERIOD  = 10,
  parameter int         GRID_W       = 16,
  parameter int         GRID_H       = 12,
  parameter int         MAX_LEN      = 7,
  parameter int         HIT_COOLDOWN = 30,
  parameter logic [7:0] START_POS    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic [7:0] target_pos,
  input  logic       heal_req,
  input  logic       hit_req,
  output logic [9:0] dragon_head,
  output logic [5:0] movement_counter,
  output logic [1:0] length_update,
  output logic [2:0] length_count,
  output logic       invulnerable
);

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_RIGHT = 2'd1;
  localparam logic [1:0] D_DOWN  = 2'd2;
  localparam logic [1:0] D_LEFT  = 2'd3;

  localparam logic [3:0] X_MAX   = 4'(GRID_W - 1);
  localparam logic [3:0] Y_MAX   = 4'(GRID_H - 1);
  localparam logic [5:0] MP      = 6'(MOVE_PERIOD);
  localparam logic [2:0] LEN_MAX = 3'(MAX_LEN);
  localparam logic [7:0] CD_LOAD = 8'(HIT_COOLDOWN);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    COOLDOWN
  } state_t;

  state_t     state;
  logic       vsync_d;
  logic       heal_d;
  logic       hit_d;
  logic [7:0] cd_cnt;

  logic       frame_tick;
  logic       heal_edge;
  logic       hit_edge;
  logic       heal_ok;

  logic [1:0] orient;
  logic [3:0] hx;
  logic [3:0] hy;
  logic [3:0] tx;
  logic [3:0] ty;
  logic       dx_nz;
  logic       dy_nz;
  logic [1:0] xdir;
  logic [1:0] ydir;
  logic [1:0] want;
  logic [1:0] step_dir;
  logic       step_en;
  logic [3:0] nx;
  logic [3:0] ny;

  assign frame_tick = vsync & ~vsync_d;
  assign heal_edge  = heal_req & ~heal_d;
  assign hit_edge   = hit_req & ~hit_d;
  assign heal_ok    = heal_edge && (length_count != LEN_MAX);

  assign orient = dragon_head[9:8];
  assign hx     = dragon_head[7:4];
  assign hy     = dragon_head[3:0];

  assign tx = (target_pos[7:4] > X_MAX) ? X_MAX : target_pos[7:4];
  assign ty = (target_pos[3:0] > Y_MAX) ? Y_MAX : target_pos[3:0];

  assign dx_nz = (hx != tx);
  assign dy_nz = (hy != ty);
  assign xdir  = (tx > hx) ? D_RIGHT : D_LEFT;
  assign ydir  = (ty > hy) ? D_DOWN : D_UP;
  assign want  = dx_nz ? xdir : ydir;

  function automatic logic fits(input logic [1:0] d,
                                input logic [3:0] x,
                                input logic [3:0] y);
    logic ok;
    unique case (d)
      D_UP:    ok = (y != 4'd0);
      D_RIGHT: ok = (x < X_MAX);
      D_DOWN:  ok = (y < Y_MAX);
      default: ok = (x != 4'd0);
    endcase
    return ok;
  endfunction

  // pick the step direction, avoiding a reversal onto the body
  always_comb begin
    step_dir = orient;
    step_en  = 1'b0;
    if (dx_nz | dy_nz) begin
      if (want != (orient ^ 2'b10)) begin
        step_dir = want;
        step_en  = 1'b1;
      end else if (dx_nz & dy_nz) begin
        step_dir = ydir;
        step_en  = 1'b1;
      end else if (fits(orient + 2'd1, hx, hy)) begin
        step_dir = orient + 2'd1;
        step_en  = 1'b1;
      end else if (fits(orient - 2'd1, hx, hy)) begin
        step_dir = orient - 2'd1;
        step_en  = 1'b1;
      end
    end
  end

  // next tile for the chosen direction
  always_comb begin
    nx = hx;
    ny = hy;
    unique case (step_dir)
      D_UP:    ny = hy - 4'd1;
      D_RIGHT: nx = hx + 4'd1;
      D_DOWN:  ny = hy + 4'd1;
      D_LEFT:  nx = hx - 4'd1;
    endcase
  end

  // frame counter and head step on the wrapping tick
  always_ff @(posedge clk) begin
    if (!reset) begin
      vsync_d          <= 1'b0;
      movement_counter <= '0;
      dragon_head      <= {D_RIGHT, START_POS};
    end else begin
      vsync_d <= vsync;
      if (frame_tick) begin
        if (movement_counter == MP) begin
          movement_counter <= '0;
          if (step_en) begin
            dragon_head <= {step_dir, nx, ny};
          end
        end else begin
          movement_counter <= movement_counter + 6'd1;
        end
      end
    end
  end

  // length FSM: grow/shrink pulses and hit cooldown
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      heal_d        <= 1'b0;
      hit_d         <= 1'b0;
      length_update <= 2'b00;
      length_count  <= '0;
      invulnerable  <= 1'b0;
      cd_cnt        <= '0;
    end else begin
      heal_d        <= heal_req;
      hit_d         <= hit_req;
      length_update <= 2'b00;
      if (invulnerable && frame_tick && cd_cnt != 8'd0) begin
        cd_cnt <= cd_cnt - 8'd1;
      end
      unique case (state)
        IDLE: begin
          if (hit_edge) begin
            invulnerable <= 1'b1;
            cd_cnt       <= CD_LOAD;
            if (length_count != 3'd0) begin
              length_update <= 2'b10;
              length_count  <= length_count - 3'd1;
              state         <= PULSE;
            end else begin
              state <= COOLDOWN;
            end
          end else if (heal_ok) begin
            length_update <= 2'b01;
            length_count  <= length_count + 3'd1;
            state         <= PULSE;
          end
        end
        PULSE: begin
          state <= invulnerable ? COOLDOWN : IDLE;
        end
        COOLDOWN: begin
          if (heal_ok) begin
            length_update <= 2'b01;
            length_count  <= length_count + 3'd1;
            state         <= PULSE;
          end else if (cd_cnt == 8'd0) begin
            state <= IDLE;
          end
          if (cd_cnt == 8'd0) begin
            invulnerable <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dragon_head_ctrl.sv
// tb_dragon_head_ctrl: scoreboard bench for the dragon head controller,
// random and directed stimulus against a tile-level reference model.
module tb_dragon_head_ctrl;

  localparam int MP = 10;
  localparam int GW = 16;
  localparam int GH = 12;
  localparam int ML = 7;
  localparam int CD = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vsync = 1'b0;
  logic [7:0] target_pos = 8'h00;
  logic       heal_req = 1'b0;
  logic       hit_req = 1'b0;
  logic [9:0] dragon_head;
  logic [5:0] movement_counter;
  logic [1:0] length_update;
  logic [2:0] length_count;
  logic       invulnerable;

  dragon_head_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .vsync            (vsync),
    .target_pos       (target_pos),
    .heal_req         (heal_req),
    .hit_req          (hit_req),
    .dragon_head      (dragon_head),
    .movement_counter (movement_counter),
    .length_update    (length_update),
    .length_count     (length_count),
    .invulnerable     (invulnerable)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [9:0] head_q[$];
  logic [5:0] cnt_q[$];
  logic [4:0] pulse_q[$];
  logic       inv_q[$];
  bit         mon_en = 1'b0;

  // reference model state
  int mx, my, mo, mcnt, mlen, mcd;
  int ddx[4] = '{0, 1, 0, -1};
  int ddy[4] = '{-1, 0, 1, 0};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: changed to %0h with nothing expected", name, act);
  endtask

  function automatic bit in_grid(input int x, input int y);
    return x >= 0 && x < GW && y >= 0 && y < GH;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mo = 1; mcnt = 0; mlen = 0; mcd = 0;
    head_q.delete(); cnt_q.delete(); pulse_q.delete(); inv_q.delete();
  endtask

  task automatic model_step();
    int tx, ty, dx, dy, want, dir, cw, ccw;
    tx = int'(target_pos[7:4]);
    ty = int'(target_pos[3:0]);
    if (tx > GW - 1) tx = GW - 1;
    if (ty > GH - 1) ty = GH - 1;
    dx = tx - mx;
    dy = ty - my;
    if (dx == 0 && dy == 0) return;
    if (dx != 0) want = (dx > 0) ? 1 : 3;
    else want = (dy > 0) ? 2 : 0;
    cw = (mo + 1) % 4;
    ccw = (mo + 3) % 4;
    dir = -1;
    if (want != (mo + 2) % 4) dir = want;
    else if (dx != 0 && dy != 0) dir = (dy > 0) ? 2 : 0;
    else if (in_grid(mx + ddx[cw], my + ddy[cw])) dir = cw;
    else if (in_grid(mx + ddx[ccw], my + ddy[ccw])) dir = ccw;
    if (dir < 0) return;
    mx += ddx[dir];
    my += ddy[dir];
    mo = dir;
    head_q.push_back({2'(mo), 4'(mx), 4'(my)});
  endtask

  task automatic tick();
    @(negedge clk);
    vsync = 1'b1;
    if (mcnt == MP) begin
      mcnt = 0;
      model_step();
    end else begin
      mcnt++;
    end
    cnt_q.push_back(6'(mcnt));
    if (mcd > 0) begin
      mcd--;
      if (mcd == 0) inv_q.push_back(1'b0);
    end
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic request(input bit h, input bit k);
    @(negedge clk);
    heal_req = h;
    hit_req = k;
    if (k && mcd == 0) begin
      mcd = CD;
      inv_q.push_back(1'b1);
      if (mlen > 0) begin
        mlen--;
        pulse_q.push_back({2'b10, 3'(mlen)});
      end
    end else if (h && mlen < ML) begin
      mlen++;
      pulse_q.push_back({2'b01, 3'(mlen)});
    end
    repeat (2) @(negedge clk);
    heal_req = 1'b0;
    hit_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    vsync = 1'b0;
    heal_req = 1'b0;
    hit_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_head", dragon_head, 10'h100);
    check("rst_counter", movement_counter, 6'd0);
    check("rst_update", length_update, 2'b00);
    check("rst_length", length_count, 3'd0);
    check("rst_invuln", invulnerable, 1'b0);
    model_reset();
    mon_en = 1'b1;
  endtask

  // monitor: compare every observed output change against the queues
  logic [9:0] p_head;
  logic [5:0] p_cnt;
  logic [1:0] p_lu;
  logic [2:0] p_len;
  logic       p_inv;

  always @(negedge clk) begin
    if (mon_en) begin
      if (dragon_head !== p_head) begin
        if (head_q.size() == 0) unexpected("head", dragon_head);
        else check("head", dragon_head, head_q.pop_front());
      end
      if (movement_counter !== p_cnt) begin
        if (cnt_q.size() == 0) unexpected("counter", movement_counter);
        else check("counter", movement_counter, cnt_q.pop_front());
      end
      if (length_update !== 2'b00) begin
        check("pulse_width", p_lu, 2'b00);
        if (pulse_q.size() == 0) unexpected("pulse", {length_update, length_count});
        else check("pulse", {length_update, length_count}, pulse_q.pop_front());
      end else if (length_count !== p_len) begin
        unexpected("length_no_pulse", length_count);
      end
      if (invulnerable !== p_inv) begin
        if (inv_q.size() == 0) unexpected("invuln", invulnerable);
        else check("invuln", invulnerable, inv_q.pop_front());
      end
    end
    p_head = dragon_head;
    p_cnt = movement_counter;
    p_lu = length_update;
    p_len = length_count;
    p_inv = invulnerable;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    do_reset();

    target_pos = 8'h30;
    repeat (33) tick();
    check("chase_x3", dragon_head, 10'h130);
    repeat (11) tick();
    check("hold_at_target", dragon_head, 10'h130);

    target_pos = 8'h50;
    repeat (22) tick();
    check("reach_50", dragon_head, 10'h150);
    target_pos = 8'h00;
    repeat (11) tick();
    check("no_reversal", dragon_head, 10'h251);

    repeat (3) request(1'b1, 1'b0);
    request(1'b0, 1'b1);
    check("len_after_hit", length_count, 3'd2);
    request(1'b0, 1'b1);
    repeat (29) tick();
    check("invuln_window", invulnerable, 1'b1);
    tick();
    check("invuln_end", invulnerable, 1'b0);

    request(1'b1, 1'b1);
    check("heal_hit_same", length_count, 3'd1);
    repeat (30) tick();
    request(1'b0, 1'b1);
    repeat (8) request(1'b1, 1'b0);
    check("heal_saturate", length_count, 3'd7);
    check("pre_reset_inv", invulnerable, 1'b1);
    check("pulses_drained", pulse_q.size(), 0);
    do_reset();

    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 11);
      if (op <= 6) tick();
      else if (op == 7) request(1'b1, 1'b0);
      else if (op == 8) request(1'b0, 1'b1);
      else if (op == 9) request(1'b1, 1'b1);
      else begin
        @(negedge clk);
        target_pos = 8'($urandom);
      end
    end

    repeat (4) @(negedge clk);
    check("head_q_empty", head_q.size(), 0);
    check("cnt_q_empty", cnt_q.size(), 0);
    check("pulse_q_empty", pulse_q.size(), 0);
    check("inv_q_empty", inv_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
